// File: rtl/pingpong_pkg.sv
// Shared definitions for the N-channel ping-pong write scheduler.
//   state_t : FSM state encoding (IDLE..HALT), 3 bits wide.
//   clogb2  : ceil(log2(n)) with a minimum of 1 bit, used to size channel indices.
package pingpong_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARM  = 3'd1,
        RUN  = 3'd2,
        DONE = 3'd3,
        HALT = 3'd4
    } state_t;

    function automatic int unsigned clogb2(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/pp_chan_addr.sv
// Per-channel bias address register.
//   clk, rst_n  : clock, async active-low reset (bias returns to OFFSET)
//   reload      : restore OFFSET (session start / restart after halt)
//   advance     : step bias by ADVANCE (this channel finished a burst)
//   end_addr    : exclusive upper limit for the in-range flag
//   bias        : registered bias address
//   in_range_c  : bias < end_addr (combinational)
module pp_chan_addr
    import pingpong_pkg::*;
#(
    parameter int unsigned         ADDR_W  = 32,
    parameter logic [ADDR_W-1:0]   OFFSET  = '0,
    parameter logic [ADDR_W-1:0]   ADVANCE = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              reload,
    input  logic              advance,
    input  logic [ADDR_W-1:0] end_addr,
    output logic [ADDR_W-1:0] bias,
    output logic              in_range_c
);

    logic [ADDR_W:0]   sum_c;
    logic [ADDR_W-1:0] bias_d;

    // Carry out of the advance saturates the bias so it can never wrap back into range.
    always_comb begin
        sum_c  = {1'b0, bias} + {1'b0, ADVANCE};
        bias_d = bias;
        if (reload) begin
            bias_d = OFFSET;
        end else if (advance) begin
            bias_d = sum_c[ADDR_W] ? '1 : sum_c[ADDR_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bias <= OFFSET;
        end else begin
            bias <= bias_d;
        end
    end

    assign in_range_c = ({1'b0, bias} < {1'b0, end_addr});

endmodule

// File: rtl/pingpong_nway_sched.sv
// N-channel round-robin burst scheduler feeding NUM_CH AXI write engines.
//   start/data_en/data     : session control and source stream
//   warn_thres/cancel_thres: FIFO halt / resume hysteresis thresholds
//   fifo_cnt               : packed per-channel FIFO occupancy
//   end_addr               : exclusive bias limit
//   txn_done/wready_in     : per-channel burst complete / WREADY
//   wready_out             : WREADY of the active channel (combinational)
//   txn_init/wvalid/wdata  : per-channel burst start, data enable, shared data
//   bias_addr              : packed per-channel bias address
//   act_ch/state           : active channel, FSM state
//   write_done/halted/restart_cnt : session status
module pingpong_nway_sched
    import pingpong_pkg::*;
#(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned BURST_LEN = 16,
    parameter int unsigned CNT_W     = 8,
    localparam int unsigned CH_W     = clogb2(NUM_CH)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       data_en,
    input  logic [DATA_W-1:0]          data,
    input  logic [CNT_W-1:0]           warn_thres,
    input  logic [CNT_W-1:0]           cancel_thres,
    input  logic [NUM_CH*CNT_W-1:0]    fifo_cnt,
    input  logic [ADDR_W-1:0]          end_addr,
    input  logic [NUM_CH-1:0]          txn_done,
    input  logic [NUM_CH-1:0]          wready_in,
    output logic                       wready_out,
    output logic [NUM_CH-1:0]          txn_init,
    output logic [NUM_CH*ADDR_W-1:0]   bias_addr,
    output logic [NUM_CH-1:0]          wvalid,
    output logic [DATA_W-1:0]          wdata,
    output logic [CH_W-1:0]            act_ch,
    output logic [2:0]                 state,
    output logic                       write_done,
    output logic                       halted,
    output logic [7:0]                 restart_cnt
);

    localparam int unsigned STRIDE  = BURST_LEN * DATA_W / 8;
    localparam int unsigned ADVANCE = NUM_CH * STRIDE;

    state_t            state_q, state_d;
    logic [CH_W-1:0]   act_ch_q, act_ch_d, nxt_c;
    logic              prearm_q, prearm_d;
    logic              armed_q, armed_d;
    logic              de_q;
    logic              warn_c, clear_c, nxt_in_range_c, nxt_armed_c, de_rise_c, reload_c;
    logic [NUM_CH-1:0] in_range, adv_c, txn_init_d, wvalid_d;
    logic              write_done_d, halted_d;
    logic [7:0]        restart_d;

    // Warning when any FIFO reaches warn_thres; clear only when every FIFO is at/below cancel_thres.
    always_comb begin
        warn_c  = 1'b0;
        clear_c = 1'b1;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (fifo_cnt[k*CNT_W +: CNT_W] >= warn_thres)  warn_c  = 1'b1;
            if (fifo_cnt[k*CNT_W +: CNT_W] > cancel_thres) clear_c = 1'b0;
        end
    end

    // Successor channel and its in-range flag.
    always_comb begin
        nxt_c          = (act_ch_q == CH_W'(NUM_CH - 1)) ? '0 : act_ch_q + CH_W'(1);
        nxt_in_range_c = 1'b0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (CH_W'(k) == nxt_c) nxt_in_range_c = in_range[k];
        end
    end

    // Successor counts as armed once its pre-arm pulse is issued (or is being issued now).
    assign nxt_armed_c = armed_q | (prearm_q & nxt_in_range_c);
    assign de_rise_c   = data_en & ~de_q;
    assign reload_c    = ((state_q == IDLE) || (state_q == HALT)) && (state_d == ARM);
    assign adv_c       = ((state_q != IDLE) && (state_q != HALT)) ? txn_done : '0;

    // Next-state and registered-output decode.
    always_comb begin
        state_d      = state_q;
        act_ch_d     = act_ch_q;
        prearm_d     = 1'b0;
        armed_d      = 1'b0;
        txn_init_d   = '0;
        wvalid_d     = '0;
        write_done_d = write_done;
        halted_d     = halted;
        restart_d    = restart_cnt;

        unique case (state_q)
            IDLE: if (start) state_d = ARM;
            ARM: begin
                if (!start)         state_d = IDLE;
                else if (warn_c)    state_d = HALT;
                else if (de_rise_c) state_d = RUN;
            end
            RUN: begin
                if (!start)      state_d = IDLE;
                else if (warn_c) state_d = HALT;
                else if (txn_done[act_ch_q]) begin
                    if (nxt_armed_c) act_ch_d = nxt_c;
                    else             state_d  = DONE;
                end
            end
            DONE: if (!start) state_d = IDLE;
            HALT: begin
                if (!start)       state_d = IDLE;
                else if (clear_c) state_d = ARM;
            end
            default: state_d = IDLE;
        endcase

        if ((state_d == IDLE) || (state_d == ARM)) act_ch_d = '0;

        // Channel 0 always gets one burst on ARM entry, regardless of range.
        if ((state_d == ARM) && (state_q != ARM)) txn_init_d[0] = 1'b1;

        if ((state_q == RUN) && (state_d == RUN) && prearm_q) begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                if (CH_W'(k) == nxt_c) txn_init_d[k] = nxt_in_range_c;
            end
        end

        if (state_d == RUN) begin
            prearm_d = (state_q != RUN) || (act_ch_d != act_ch_q);
            armed_d  = ((state_q == RUN) && (act_ch_d == act_ch_q)) ? nxt_armed_c : 1'b0;
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                if (CH_W'(k) == act_ch_d) wvalid_d[k] = data_en;
            end
        end

        if ((state_q == IDLE) && (state_d == ARM)) begin
            write_done_d = 1'b0;
            halted_d     = 1'b0;
        end
        if (state_d == DONE) write_done_d = 1'b1;
        if ((state_d == HALT) && (state_q != HALT)) begin
            halted_d = 1'b1;
            if (restart_cnt != 8'hFF) restart_d = restart_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            act_ch_q    <= '0;
            prearm_q    <= 1'b0;
            armed_q     <= 1'b0;
            de_q        <= 1'b0;
            txn_init    <= '0;
            wvalid      <= '0;
            wdata       <= '0;
            write_done  <= 1'b0;
            halted      <= 1'b0;
            restart_cnt <= '0;
        end else begin
            state_q     <= state_d;
            act_ch_q    <= act_ch_d;
            prearm_q    <= prearm_d;
            armed_q     <= armed_d;
            de_q        <= data_en;
            txn_init    <= txn_init_d;
            wvalid      <= wvalid_d;
            wdata       <= data;
            write_done  <= write_done_d;
            halted      <= halted_d;
            restart_cnt <= restart_d;
        end
    end

    assign state  = state_q;
    assign act_ch = act_ch_q;

    always_comb begin
        wready_out = 1'b0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (CH_W'(k) == act_ch_q) wready_out = wready_in[k];
        end
    end

    // Channel k starts at k*STRIDE and steps by NUM_CH*STRIDE, interleaving the address space.
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        pp_chan_addr #(
            .ADDR_W  (ADDR_W),
            .OFFSET  (ADDR_W'(k * STRIDE)),
            .ADVANCE (ADDR_W'(ADVANCE))
        ) u_addr (
            .clk        (clk),
            .rst_n      (rst_n),
            .reload     (reload_c),
            .advance    (adv_c[k]),
            .end_addr   (end_addr),
            .bias       (bias_addr[k*ADDR_W +: ADDR_W]),
            .in_range_c (in_range[k])
        );
    end

endmodule

// File: tb/tb_pingpong_nway_sched.sv
`timescale 1ns/1ps
module tb_pingpong_nway_sched;

    localparam logic [2:0] S_IDLE = 3'd0, S_ARM = 3'd1, S_RUN = 3'd2, S_DONE = 3'd3, S_HALT = 3'd4;
    localparam logic [127:0] RST_BIAS  = {32'h0C0, 32'h080, 32'h040, 32'h000};
    localparam logic [63:0]  RST_BIAS2 = {32'h040, 32'h000};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, start, start2, data_en;
    logic [31:0]  data, data_last, end_addr;
    logic [7:0]   warn_thres, cancel_thres;
    logic [31:0]  fifo_cnt;
    logic [15:0]  fifo_cnt2;
    logic [3:0]   txn_done, wready_in, txn_init, wvalid;
    logic [1:0]   txn_done2, wready_in2, txn_init2, wvalid2;
    logic         wready_out, wready_out2, write_done, write_done2, halted, halted2;
    logic [127:0] bias_addr;
    logic [63:0]  bias_addr2;
    logic [31:0]  wdata, wdata2;
    logic [1:0]   act_ch;
    logic [0:0]   act_ch2;
    logic [2:0]   state, state2;
    logic [7:0]   restart_cnt, restart_cnt2;

    pingpong_nway_sched #(.NUM_CH(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .data_en(data_en), .data(data),
        .warn_thres(warn_thres), .cancel_thres(cancel_thres), .fifo_cnt(fifo_cnt),
        .end_addr(end_addr), .txn_done(txn_done), .wready_in(wready_in),
        .wready_out(wready_out), .txn_init(txn_init), .bias_addr(bias_addr),
        .wvalid(wvalid), .wdata(wdata), .act_ch(act_ch), .state(state),
        .write_done(write_done), .halted(halted), .restart_cnt(restart_cnt)
    );

    pingpong_nway_sched #(.NUM_CH(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .data_en(data_en), .data(data),
        .warn_thres(warn_thres), .cancel_thres(cancel_thres), .fifo_cnt(fifo_cnt2),
        .end_addr(end_addr), .txn_done(txn_done2), .wready_in(wready_in2),
        .wready_out(wready_out2), .txn_init(txn_init2), .bias_addr(bias_addr2),
        .wvalid(wvalid2), .wdata(wdata2), .act_ch(act_ch2), .state(state2),
        .write_done(write_done2), .halted(halted2), .restart_cnt(restart_cnt2)
    );

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int unsigned ch;
        logic [31:0] bias;
    } exp_t;
    exp_t q1[$];
    exp_t q2[$];
    exp_t m1, m2;
    logic mon_en = 1'b0;

    typedef struct packed {
        logic       start;
        logic       de;
        logic [3:0] done;
        logic [2:0] st;
        logic [1:0] act;
        logic [3:0] init;
        logic [3:0] wv;
    } vec_t;
    vec_t tbl[9];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push1(input int unsigned ch, input logic [31:0] b);
        exp_t e;
        e.ch = ch; e.bias = b;
        q1.push_back(e);
    endtask

    task automatic push2(input int unsigned ch, input logic [31:0] b);
        exp_t e;
        e.ch = ch; e.bias = b;
        q2.push_back(e);
    endtask

    // One clock; wdata must echo the data present at the edge.
    task automatic step();
        @(posedge clk);
        #1;
        chk("wdata", 128'(wdata), 128'(data_last));
        chk("wdata2", 128'(wdata2), 128'(data_last));
        data      = $urandom;
        data_last = data;
    endtask

    // Scoreboard: every txn_init pulse must match the next expected {channel, bias}.
    always begin
        @(posedge clk);
        #2;
        if (mon_en) begin
            chk("wvalid_onehot0", 128'($onehot0(wvalid)), 128'(1));
            if (txn_init != 4'b0) begin
                if (q1.size() == 0) chk("init_unexpected", 128'(txn_init), 128'(0));
                else begin
                    m1 = q1.pop_front();
                    chk("init_ch", 128'(txn_init), 128'(4'(4'b1 << m1.ch)));
                    chk("init_bias", 128'(bias_addr[m1.ch*32 +: 32]), 128'(m1.bias));
                end
            end
        end
        chk("wvalid2_onehot0", 128'($onehot0(wvalid2)), 128'(1));
        if (txn_init2 != 2'b0) begin
            if (q2.size() == 0) chk("init2_unexpected", 128'(txn_init2), 128'(0));
            else begin
                m2 = q2.pop_front();
                chk("init2_ch", 128'(txn_init2), 128'(2'(2'b1 << m2.ch)));
                chk("init2_bias", 128'(bias_addr2[m2.ch*32 +: 32]), 128'(m2.bias));
            end
        end
    end

    initial begin
        //            start de    done  st     act   init  wv
        tbl[0] = {1'b1, 1'b0, 4'h0, S_ARM,  2'd0, 4'h1, 4'h0};
        tbl[1] = {1'b1, 1'b0, 4'h0, S_ARM,  2'd0, 4'h0, 4'h0};
        tbl[2] = {1'b1, 1'b1, 4'h0, S_RUN,  2'd0, 4'h0, 4'h1};
        tbl[3] = {1'b1, 1'b1, 4'h0, S_RUN,  2'd0, 4'h2, 4'h1};
        tbl[4] = {1'b1, 1'b0, 4'h0, S_RUN,  2'd0, 4'h0, 4'h0};
        tbl[5] = {1'b1, 1'b1, 4'h1, S_RUN,  2'd1, 4'h0, 4'h2};
        tbl[6] = {1'b1, 1'b1, 4'h0, S_RUN,  2'd1, 4'h4, 4'h2};
        tbl[7] = {1'b0, 1'b0, 4'h0, S_IDLE, 2'd0, 4'h0, 4'h0};
        tbl[8] = {1'b0, 1'b0, 4'h2, S_IDLE, 2'd0, 4'h0, 4'h0};

        rst_n = 1'b0; start = 1'b0; start2 = 1'b0; data_en = 1'b0;
        data = 32'h0; data_last = 32'h0; end_addr = 32'h400;
        warn_thres = 8'd192; cancel_thres = 8'd64;
        fifo_cnt = 32'h0; fifo_cnt2 = 16'h0;
        txn_done = 4'h0; txn_done2 = 2'h0; wready_in = 4'h0; wready_in2 = 2'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ctl", 128'({state, act_ch, txn_init, wvalid, write_done, halted, restart_cnt}), 128'(0));
        chk("rst_wdata", 128'(wdata), 128'(0));
        chk("rst_bias", bias_addr, RST_BIAS);
        chk("rst_bias2", 128'(bias_addr2), 128'(RST_BIAS2));
        rst_n = 1'b1;

        // Cycle-by-cycle session entry, channel switch and abort.
        for (int i = 0; i < 9; i++) begin
            logic [3:0] sel;
            start = tbl[i].start; data_en = tbl[i].de; txn_done = tbl[i].done;
            step();
            txn_done = 4'h0;
            chk($sformatf("vec%0d", i), 128'({state, act_ch, txn_init, wvalid}),
                128'({tbl[i].st, tbl[i].act, tbl[i].init, tbl[i].wv}));
            sel = 4'b1 << tbl[i].act;
            wready_in = sel;
            #1 chk($sformatf("wready_hi%0d", i), 128'(wready_out), 128'(1));
            wready_in = ~sel;
            #1 chk($sformatf("wready_lo%0d", i), 128'(wready_out), 128'(0));
        end
        chk("bias_after_tbl", bias_addr, {32'h0C0, 32'h080, 32'h040, 32'h100});

        // Full session: 16 bursts round-robin, biases interleaved.
        mon_en = 1'b1;
        for (int i = 0; i < 16; i++) push1(32'(i % 4), 32'(i * 64));
        start = 1'b1;
        step();
        data_en = 1'b1;
        step();
        for (int b = 0; b < 16; b++) begin
            repeat (19) step();
            txn_done = 4'(4'b1 << (b % 4));
            step();
            txn_done = 4'h0;
        end
        step();
        chk("full_state", 128'(state), 128'(S_DONE));
        chk("full_wdone", 128'(write_done), 128'(1));
        chk("full_wvalid", 128'(wvalid), 128'(0));
        chk("full_sb_empty", 128'(q1.size()), 128'(0));

        // Halt on FIFO warning, resume on hysteresis clear.
        start = 1'b0; data_en = 1'b0;
        step();
        chk("halt_idle", 128'(state), 128'(S_IDLE));
        start = 1'b1; push1(0, 32'h0);
        step();
        chk("halt_arm", 128'({state, write_done, halted}), 128'({S_ARM, 1'b0, 1'b0}));
        data_en = 1'b1; push1(1, 32'h40);
        step();
        step();
        txn_done = 4'h1; push1(2, 32'h80);
        step();
        txn_done = 4'h0;
        chk("halt_act1", 128'(act_ch), 128'(1));
        step();
        fifo_cnt[16 +: 8] = 8'd200;
        step();
        chk("halt_enter", 128'({state, wvalid, restart_cnt, halted}), 128'({S_HALT, 4'h0, 8'd1, 1'b1}));
        step();
        chk("halt_hold", 128'({state, txn_init}), 128'({S_HALT, 4'h0}));
        fifo_cnt = {8'd5, 8'd64, 8'd64, 8'd0}; push1(0, 32'h0);
        step();
        chk("resume_arm", 128'({state, act_ch, restart_cnt}), 128'({S_ARM, 2'd0, 8'd1}));
        chk("resume_bias", bias_addr, RST_BIAS);
        data_en = 1'b0;
        step();
        chk("resume_wait", 128'(state), 128'(S_ARM));
        data_en = 1'b1; push1(1, 32'h40);
        step();
        chk("resume_run", 128'(state), 128'(S_RUN));
        step();
        // txn_done and warning together: warning wins.
        txn_done = 4'h1; fifo_cnt[8 +: 8] = 8'd250;
        step();
        txn_done = 4'h0;
        chk("done_vs_warn", 128'({state, act_ch, txn_init, restart_cnt}), 128'({S_HALT, 2'd0, 4'h0, 8'd2}));
        step();
        chk("done_vs_warn2", 128'({state, txn_init}), 128'({S_HALT, 4'h0}));
        start = 1'b0; fifo_cnt = 32'h0;
        step();
        chk("halt_abort", 128'(state), 128'(S_IDLE));
        chk("halt_sb_empty", 128'(q1.size()), 128'(0));

        // Short address window: only ch0..ch2 get bursts.
        end_addr = 32'h0A0; data_en = 1'b0; start = 1'b1;
        push1(0, 32'h0); push1(1, 32'h40); push1(2, 32'h80);
        step();
        data_en = 1'b1;
        step();
        for (int b = 0; b < 3; b++) begin
            repeat (5) step();
            txn_done = 4'(4'b1 << b);
            step();
            txn_done = 4'h0;
        end
        step();
        chk("win_state", 128'({state, write_done}), 128'({S_DONE, 1'b1}));
        chk("win_ch3_bias", 128'(bias_addr[96 +: 32]), 128'(32'h0C0));
        repeat (3) step();
        chk("win_sb_empty", 128'(q1.size()), 128'(0));
        start = 1'b0;
        step();

        // Asynchronous reset mid-burst.
        end_addr = 32'h400; data_en = 1'b0; start = 1'b1;
        push1(0, 32'h0); push1(1, 32'h40);
        step();
        data_en = 1'b1;
        step();
        repeat (4) step();
        #3 rst_n = 1'b0;
        #1;
        chk("arst_ctl", 128'({state, act_ch, txn_init, wvalid, write_done, halted, restart_cnt}), 128'(0));
        chk("arst_bias", bias_addr, RST_BIAS);
        start = 1'b0; data_en = 1'b0;
        #2 rst_n = 1'b1;
        step();
        chk("arst_idle", 128'(state), 128'(S_IDLE));

        // Two-channel instance: classic 0,1,0,1 ping-pong.
        end_addr = 32'h200; start2 = 1'b1;
        for (int i = 0; i < 8; i++) push2(32'(i % 2), 32'(i * 64));
        step();
        data_en = 1'b1;
        step();
        for (int b = 0; b < 8; b++) begin
            repeat (4) step();
            txn_done2 = 2'(2'b1 << (b % 2));
            step();
            txn_done2 = 2'h0;
        end
        step();
        chk("pp2_state", 128'({state2, write_done2}), 128'({S_DONE, 1'b1}));
        chk("pp2_sb_empty", 128'(q2.size()), 128'(0));
        start2 = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
